// File: rtl/mm2s_stream_checker_if.sv
// -----------------------------------------------------------------------------
// mm2s_stream_checker_if
// Bundles the datamover MM2S data stream and MM2S status stream seen by
// mm2s_stream_checker.
//   s_axis_tdata/tkeep/tlast/tvalid : MM2S data beat, driven by the datamover
//   s_axis_tready                   : paced ready, driven by the checker
//   s_sts_tdata/tkeep/tlast/tvalid  : MM2S status byte, driven by the datamover
//   s_sts_tready                    : status ready, driven by the checker
// Modports:
//   master : datamover side (drives data/status, observes readies)
//   slave  : checker side (observes data/status, drives readies)
// -----------------------------------------------------------------------------
interface mm2s_stream_checker_if #(
   parameter int W = 64
);
   logic [W-1:0]   s_axis_tdata;
   logic [W/8-1:0] s_axis_tkeep;
   logic           s_axis_tlast;
   logic           s_axis_tvalid;
   logic           s_axis_tready;

   logic [7:0]     s_sts_tdata;
   logic           s_sts_tkeep;
   logic           s_sts_tlast;
   logic           s_sts_tvalid;
   logic           s_sts_tready;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      output s_sts_tdata, s_sts_tkeep, s_sts_tlast, s_sts_tvalid,
      input  s_sts_tready
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      input  s_sts_tdata, s_sts_tkeep, s_sts_tlast, s_sts_tvalid,
      output s_sts_tready
   );
endinterface

// File: rtl/mm2s_stream_checker.sv
// -----------------------------------------------------------------------------
// mm2s_stream_checker
// Read-back end of the DDR capture path. Drains one block from the datamover
// MM2S stream at one beat per RD_DIV cycles, checks every beat against the
// incrementing pattern starting at seed, checks block length and the status
// byte, and reports a pass/fail summary with first-error capture.
//
// Optional build macro: MM2S_CHK_RESYNC_EN
//   defined   : on a mismatching beat the expected value re-locks to tdata+1
//   undefined : expected always advances from seed
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, arms a block check (any state)
//   seed              : expected value of beat 0, sampled on start
//   bus (slave)       : MM2S data + status streams and their readies
//   busy              : state is RUN or WAIT_STS
//   done              : level, block finished
//   pass              : block clean; valid while done
//   word_count        : beats accepted
//   err_count         : mismatching beats, saturating
//   len_err           : tlast position wrong
//   sts_err           : bad status byte
//   sts_tag           : tag of the accepted status byte
//   first_err_index   : beat index of the first mismatch
//   first_err_data    : received data at the first mismatch
//   first_err_expect  : expected data at the first mismatch
// -----------------------------------------------------------------------------
module mm2s_stream_checker #(
   parameter int         W           = 64,
   parameter int         RD_DIV      = 64,
   parameter int         BLOCK_WORDS = 512,
   parameter logic [3:0] EXP_TAG     = 4'hA
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [W-1:0]        seed,
   mm2s_stream_checker_if.slave bus,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [31:0]         word_count,
   output logic [31:0]         err_count,
   output logic                len_err,
   output logic                sts_err,
   output logic [3:0]          sts_tag,
   output logic [31:0]         first_err_index,
   output logic [W-1:0]        first_err_data,
   output logic [W-1:0]        first_err_expect
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_WAIT_STS = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam int          DW       = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(RD_DIV - 1);
   localparam logic [31:0] LAST_IDX = 32'(BLOCK_WORDS - 1);
   localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

   logic [1:0]    state, state_n;
   logic [W-1:0]  expected, expected_n;
   logic [DW-1:0] div, div_n;
   logic          data_done, data_done_n;
   logic          got_sts, got_sts_n;
   logic          tready_r, tready_n;
   logic          pass_n;
   logic [31:0]   word_count_n, err_count_n;
   logic          len_err_n, sts_err_n;
   logic [3:0]    sts_tag_n;
   logic [31:0]   first_err_index_n;
   logic [W-1:0]  first_err_data_n, first_err_expect_n;

   logic          beat, sts_take, mismatch, sts_bad, at_last;

   // status tkeep/tlast carry no information for this checker
   logic          unused_sts;
   assign unused_sts = bus.s_sts_tkeep ^ bus.s_sts_tlast;

   assign bus.s_axis_tready = tready_r;
   assign bus.s_sts_tready  = 1'b1;
   assign busy              = (state == S_RUN) || (state == S_WAIT_STS);
   assign done              = (state == S_DONE);

   always_comb begin
      state_n            = state;
      expected_n         = expected;
      div_n              = div;
      data_done_n        = data_done;
      got_sts_n          = got_sts;
      word_count_n       = word_count;
      err_count_n        = err_count;
      len_err_n          = len_err;
      sts_err_n          = sts_err;
      sts_tag_n          = sts_tag;
      first_err_index_n  = first_err_index;
      first_err_data_n   = first_err_data;
      first_err_expect_n = first_err_expect;

      // tready_r is only ever raised for the RUN state with data still open
      beat     = bus.s_axis_tvalid && tready_r;
      sts_take = bus.s_sts_tvalid && !got_sts &&
                 ((state == S_RUN) || (state == S_WAIT_STS));
      mismatch = (bus.s_axis_tdata != expected) || (bus.s_axis_tkeep != '1);
      sts_bad  = !bus.s_sts_tdata[7] || (|bus.s_sts_tdata[6:4]) ||
                 (bus.s_sts_tdata[3:0] != EXP_TAG);
      at_last  = (word_count == LAST_IDX);

      if (start) begin
         expected_n         = seed;
         div_n              = DIV_MAX;
         data_done_n        = 1'b0;
         got_sts_n          = 1'b0;
         word_count_n       = '0;
         err_count_n        = '0;
         len_err_n          = 1'b0;
         sts_err_n          = 1'b0;
         sts_tag_n          = '0;
         first_err_index_n  = '0;
         first_err_data_n   = '0;
         first_err_expect_n = '0;
         state_n            = S_RUN;
      end else begin
         if (state == S_RUN)
            div_n = (div == '0) ? DIV_MAX : div - DW'(1);

         if (beat) begin
            word_count_n = word_count + 32'd1;
            expected_n   = expected + ONE;
            if (mismatch) begin
               if (err_count == '0) begin
                  first_err_index_n  = word_count;
                  first_err_data_n   = bus.s_axis_tdata;
                  first_err_expect_n = expected;
               end
               if (err_count != '1)
                  err_count_n = err_count + 32'd1;
`ifdef MM2S_CHK_RESYNC_EN
               expected_n = bus.s_axis_tdata + ONE;
`endif
            end
            // tlast must appear exactly on the final beat; either a short or
            // an overlong block closes the data phase here
            if (bus.s_axis_tlast != at_last)
               len_err_n = 1'b1;
            if (bus.s_axis_tlast || at_last)
               data_done_n = 1'b1;
         end

         if (sts_take) begin
            got_sts_n = 1'b1;
            sts_tag_n = bus.s_sts_tdata[3:0];
            sts_err_n = sts_bad;
         end

         // next-state flags let a last beat and a status in the same cycle
         // reach DONE in one step
         case (state)
            S_RUN:      if (data_done_n) state_n = got_sts_n ? S_DONE : S_WAIT_STS;
            S_WAIT_STS: if (got_sts_n)   state_n = S_DONE;
            default:    state_n = state;
         endcase
      end

      tready_n = (state_n == S_RUN) && (div_n == '0) && !data_done_n;
      pass_n   = (state_n == S_DONE) && (err_count_n == '0) &&
                 !len_err_n && !sts_err_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         expected         <= '0;
         div              <= '0;
         data_done        <= 1'b0;
         got_sts          <= 1'b0;
         tready_r         <= 1'b0;
         pass             <= 1'b0;
         word_count       <= '0;
         err_count        <= '0;
         len_err          <= 1'b0;
         sts_err          <= 1'b0;
         sts_tag          <= '0;
         first_err_index  <= '0;
         first_err_data   <= '0;
         first_err_expect <= '0;
      end else begin
         state            <= state_n;
         expected         <= expected_n;
         div              <= div_n;
         data_done        <= data_done_n;
         got_sts          <= got_sts_n;
         tready_r         <= tready_n;
         pass             <= pass_n;
         word_count       <= word_count_n;
         err_count        <= err_count_n;
         len_err          <= len_err_n;
         sts_err          <= sts_err_n;
         sts_tag          <= sts_tag_n;
         first_err_index  <= first_err_index_n;
         first_err_data   <= first_err_data_n;
         first_err_expect <= first_err_expect_n;
      end
   end

endmodule

// File: tb/tb_mm2s_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_mm2s_stream_checker
// Directed bench for mm2s_stream_checker with a reduced block (64 beats) and
// RD_DIV=4. Each block's expected summary is computed from the driven data
// and pushed to a scoreboard queue at start; it is popped and compared when
// the checker reports done.
// -----------------------------------------------------------------------------
module tb_mm2s_stream_checker;

   localparam int W      = 64;
   localparam int RD_DIV = 4;
   localparam int BW     = 64;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [W-1:0]  seed;
   logic          busy, done, pass, len_err, sts_err;
   logic [31:0]   word_count, err_count, first_err_index;
   logic [3:0]    sts_tag;
   logic [W-1:0]  first_err_data, first_err_expect;

   mm2s_stream_checker_if #(.W(W)) bus_if ();

   mm2s_stream_checker #(
      .W(W), .RD_DIV(RD_DIV), .BLOCK_WORDS(BW), .EXP_TAG(4'hA)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .bus(bus_if),
      .busy(busy), .done(done), .pass(pass),
      .word_count(word_count), .err_count(err_count),
      .len_err(len_err), .sts_err(sts_err), .sts_tag(sts_tag),
      .first_err_index(first_err_index),
      .first_err_data(first_err_data), .first_err_expect(first_err_expect)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pass;
      logic [31:0] wc;
      logic [31:0] ec;
      logic        le;
      logic        se;
      logic [3:0]  tag;
      logic [31:0] fei;
      logic [63:0] fed;
      logic [63:0] fee;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;

   logic [63:0] dat [BW];
   logic        lst [BW];
   logic [7:0]  kp  [BW];

   // tready pacing monitor
   int   cyc = 0, last_hi = 0, hi_cnt = 0, gap_viol = 0;
   logic have_hi = 1'b0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!busy) have_hi <= 1'b0;
      else if (bus_if.s_axis_tready) begin
         if (have_hi && (cyc - last_hi) != RD_DIV) gap_viol <= gap_viol + 1;
         hi_cnt  <= hi_cnt + 1;
         last_hi <= cyc;
         have_hi <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [63:0] s);
      for (int i = 0; i < BW; i++) begin
         dat[i] = s + 64'(i);
         lst[i] = (i == BW - 1);
         kp[i]  = 8'hFF;
      end
   endtask

   task automatic push_model(input logic [63:0] s, input logic [7:0] b);
      exp_t e;
      logic [63:0] ex;
      e  = '{pass: 1'b0, wc: '0, ec: '0, le: 1'b0, se: 1'b0, tag: '0,
             fei: '0, fed: '0, fee: '0};
      ex = s;
      for (int i = 0; i < BW; i++) begin
         if (dat[i] != ex || kp[i] != 8'hFF) begin
            if (e.ec == 0) begin
               e.fei = 32'(i);
               e.fed = dat[i];
               e.fee = ex;
            end
            e.ec = e.ec + 1;
         end
         ex   = ex + 64'd1;
         e.wc = e.wc + 1;
         if (lst[i] || i == BW - 1) begin
            e.le = !(lst[i] && i == BW - 1);
            break;
         end
      end
      e.tag  = b[3:0];
      e.se   = !b[7] || (b[6:4] != 3'b000) || (b[3:0] != 4'hA);
      e.pass = (e.ec == 0) && !e.le && !e.se;
      sbq.push_back(e);
   endtask

   // sts_at >= 0: status rides with the accepted beat of that index;
   // sts_at < 0: status after the data phase. n_abort > 0: stop after that
   // many beats with no completion.
   task automatic run_block(input logic [63:0] s, input logic [7:0] b,
                            input int sts_at, input int n_abort);
      int   n, idx, g, hi;
      logic acc;
      exp_t e;
      n = BW;
      for (int i = 0; i < BW; i++) if (lst[i]) begin n = i + 1; break; end
      if (n_abort > 0) n = n_abort;
      else push_model(s, b);

      @(posedge clk); #1;
      start = 1'b1; seed = s;
      bus_if.s_axis_tvalid = 1'b1;
      bus_if.s_axis_tdata  = dat[0];
      bus_if.s_axis_tlast  = lst[0];
      bus_if.s_axis_tkeep  = kp[0];
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_wc", word_count, 0);
      chk("start_ec", err_count, 0);
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);

      idx = 0; g = 0;
      while (idx < n && g < 20 * BW * RD_DIV) begin
         acc = bus_if.s_axis_tvalid && bus_if.s_axis_tready;
         if (acc && idx == sts_at) begin
            bus_if.s_sts_tvalid = 1'b1;
            bus_if.s_sts_tdata  = b;
         end
         @(posedge clk); #1;
         bus_if.s_sts_tvalid = 1'b0;
         if (acc) begin
            idx++;
            if (idx < n) begin
               bus_if.s_axis_tdata = dat[idx];
               bus_if.s_axis_tlast = lst[idx];
               bus_if.s_axis_tkeep = kp[idx];
            end else bus_if.s_axis_tvalid = 1'b0;
         end
         @(negedge clk);
         g++;
      end
      chk("beats_driven", 64'(idx), 64'(n));
      if (n_abort > 0) begin
         bus_if.s_axis_tvalid = 1'b0;
         return;
      end

      if (sts_at >= 0) chk("done_after_last", done, 1);
      else begin
         bus_if.s_axis_tvalid = 1'b1;
         bus_if.s_axis_tdata  = 64'h0BAD;
         bus_if.s_axis_tlast  = 1'b1;
         hi = 0;
         repeat (3 * RD_DIV) begin
            @(negedge clk);
            if (bus_if.s_axis_tready) hi++;
         end
         chk("tready_hold", 64'(hi), 0);
         chk("wait_sts_busy", busy, 1);
         chk("wait_sts_wc", word_count, 64'(n));
         @(posedge clk); #1;
         bus_if.s_axis_tvalid = 1'b0;
         bus_if.s_sts_tvalid  = 1'b1;
         bus_if.s_sts_tdata   = b;
         @(posedge clk); #1;
         bus_if.s_sts_tvalid  = 1'b0;
      end

      g = 0;
      while (!done && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("done_seen", done, 1);
      @(negedge clk);
      e = sbq.pop_front();
      chk("pass", pass, e.pass);
      chk("word_count", word_count, e.wc);
      chk("err_count", err_count, e.ec);
      chk("len_err", len_err, e.le);
      chk("sts_err", sts_err, e.se);
      chk("sts_tag", sts_tag, e.tag);
      chk("first_err_index", first_err_index, e.fei);
      chk("first_err_data", first_err_data, e.fed);
      chk("first_err_expect", first_err_expect, e.fee);
      chk("busy_done", busy, 0);
   endtask

   initial begin
      int h0, v0;
      reset = 1'b1; start = 1'b0; seed = '0;
      bus_if.s_axis_tdata = '0; bus_if.s_axis_tkeep = '0;
      bus_if.s_axis_tlast = 1'b0; bus_if.s_axis_tvalid = 1'b0;
      bus_if.s_sts_tdata = '0; bus_if.s_sts_tkeep = 1'b0;
      bus_if.s_sts_tlast = 1'b0; bus_if.s_sts_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_ec", err_count, 0);
      chk("rst_tready", bus_if.s_axis_tready, 0);
      chk("rst_sts_tready", bus_if.s_sts_tready, 1);

      // clean block, status early; pacing must be one tready per RD_DIV
      fill(64'd0);
      @(posedge clk); #1;
      h0 = hi_cnt; v0 = gap_viol;
      run_block(64'd0, 8'h8A, 5, 0);
      @(posedge clk); #1;
      chk("tready_highs", 64'(hi_cnt - h0), 64'(BW));
      chk("tready_gap", 64'(gap_viol - v0), 0);

      // corrupted beat, status simultaneous with the last beat
      fill(64'd0);
      dat[10] = 64'hDEAD;
      run_block(64'd0, 8'h8A, BW - 1, 0);

      // pattern wraps through all-ones to zero
      fill(64'hFFFF_FFFF_FFFF_FFFE);
      run_block(64'hFFFF_FFFF_FFFF_FFFE, 8'h8A, 3, 0);

      // short block plus a bad tkeep on a correct data beat
      fill(64'd0);
      lst[BW - 1] = 1'b0;
      lst[31]     = 1'b1;
      kp[3]       = 8'hFE;
      run_block(64'd0, 8'h8A, -1, 0);

      // missing tlast on the final beat
      fill(64'd77);
      lst[BW - 1] = 1'b0;
      run_block(64'd77, 8'h8A, -1, 0);

      // bad status bytes delivered before the last beat
      fill(64'd5);
      run_block(64'd5, 8'hCA, 7, 0);
      fill(64'd9);
      run_block(64'd9, 8'h85, 7, 0);

      // stray status in DONE is discarded
      @(posedge clk); #1;
      bus_if.s_sts_tvalid = 1'b1;
      bus_if.s_sts_tdata  = 8'h8A;
      @(posedge clk); #1;
      bus_if.s_sts_tvalid = 1'b0;
      @(negedge clk);
      chk("stray_tag", sts_tag, 4'h5);
      chk("stray_sts_err", sts_err, 1);
      chk("stray_done", done, 1);

      // start mid-block, then a clean block
      fill(64'd500);
      run_block(64'd500, 8'h8A, -1, 20);
      chk("abort_wc", word_count, 20);
      fill(64'd1000);
      run_block(64'd1000, 8'h8A, 5, 0);

      // reset mid-RUN
      fill(64'd3);
      run_block(64'd3, 8'h8A, -1, 10);
      chk("pre_reset_wc", word_count, 10);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wc", word_count, 0);
      chk("mid_rst_tready", bus_if.s_axis_tready, 0);
      chk("mid_rst_first_idx", first_err_index, 0);
      chk("mid_rst_sts_tag", sts_tag, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
